// File: rtl/sha256_msg_sched_if.sv
// Block-load and schedule-output bus between the message source, the schedule
// stage and the compression core.
interface sha256_msg_sched_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned ROUND_W = 6;

  logic                  start_in;
  logic [DATA_WIDTH-1:0] word_in;
  logic                  word_valid_in;
  logic                  word_ready_out;
  logic [DATA_WIDTH-1:0] w_out;
  logic [ROUND_W-1:0]    round_out;
  logic [1:0]            state_out;
  logic                  w_valid_out;
  logic                  done_in;
  logic                  busy_out;

  modport slave (
    input  start_in, word_in, word_valid_in, done_in,
    output word_ready_out, w_out, round_out, state_out, w_valid_out, busy_out
  );

  modport master (
    output start_in, word_in, word_valid_in, done_in,
    input  word_ready_out, w_out, round_out, state_out, w_valid_out, busy_out
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 words, expands to W[0..63] one per cycle,
// then holds the last word until the core reports the digest sent.
module sha256_msg_sched #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  sha256_msg_sched_if.slave bus
);
  localparam int unsigned ROUND_W   = 6;
  localparam int unsigned WIN_DEPTH = 16;
  localparam logic [ROUND_W-1:0] LAST_LOAD  = ROUND_W'(15);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(63);
  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_LOAD = 2'b01;
  localparam logic [1:0] PH_EXP  = 2'b10;
  localparam logic [1:0] PH_HOLD = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, HOLD} state_t;

  state_t                                 state;
  logic [ROUND_W-1:0]                     count;
  logic [WIN_DEPTH-1:0][DATA_WIDTH-1:0]   window;
  logic [DATA_WIDTH-1:0]                  w_next_c;
  logic                                   accept_c;

  function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                 input int unsigned n);
    return (x >> n) | (x << (DATA_WIDTH - n));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sigma0(input logic [DATA_WIDTH-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sigma1(input logic [DATA_WIDTH-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // window[0] is W[t-16], window[15] is W[t-1]
  always_comb begin
    w_next_c = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];
    accept_c = (state == LOAD) && bus.word_valid_in && bus.word_ready_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      count              <= '0;
      window             <= '0;
      bus.word_ready_out <= 1'b0;
      bus.w_out          <= '0;
      bus.round_out      <= '0;
      bus.state_out      <= PH_IDLE;
      bus.w_valid_out    <= 1'b0;
      bus.busy_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            state              <= LOAD;
            count              <= '0;
            bus.word_ready_out <= 1'b1;
            bus.busy_out       <= 1'b1;
          end
        end
        LOAD: begin
          if (accept_c) begin
            window          <= {bus.word_in, window[WIN_DEPTH-1:1]};
            bus.w_out       <= bus.word_in;
            bus.round_out   <= count;
            bus.w_valid_out <= 1'b1;
            bus.state_out   <= PH_LOAD;
            count           <= count + ROUND_W'(1);
            if (count == LAST_LOAD) begin
              state              <= EXPAND;
              bus.word_ready_out <= 1'b0;
            end
          end else begin
            bus.w_valid_out <= 1'b0;
            bus.state_out   <= PH_IDLE;
          end
        end
        EXPAND: begin
          // New word goes out and into the window on the same edge
          window          <= {w_next_c, window[WIN_DEPTH-1:1]};
          bus.w_out       <= w_next_c;
          bus.round_out   <= count;
          bus.w_valid_out <= 1'b1;
          bus.state_out   <= PH_EXP;
          if (count == LAST_ROUND) begin
            state <= HOLD;
          end else begin
            count <= count + ROUND_W'(1);
          end
        end
        HOLD: begin
          if (bus.done_in) begin
            state              <= IDLE;
            count              <= '0;
            window             <= '0;
            bus.word_ready_out <= 1'b0;
            bus.w_out          <= '0;
            bus.round_out      <= '0;
            bus.state_out      <= PH_IDLE;
            bus.w_valid_out    <= 1'b0;
            bus.busy_out       <= 1'b0;
          end else begin
            bus.w_valid_out <= 1'b0;
            bus.state_out   <= PH_HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: directed block runs checked against a textbook
// SHA-256 schedule model computed from the message words.
module tb_sha256_msg_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_sched_if bus ();
  sha256_msg_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] msg   [16];
  logic [31:0] ref_w [64];
  logic [31:0] got   [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void build_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) ref_w[t] = msg[t];
      else ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                    + ref_w[t-7]
                    + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                    + ref_w[t-16];
    end
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_phase"}, 32'(bus.state_out), 32'd0);
    check({tag, "_busy"},  32'(bus.busy_out), 32'd0);
    check({tag, "_valid"}, 32'(bus.w_valid_out), 32'd0);
    check({tag, "_ready"}, 32'(bus.word_ready_out), 32'd0);
    check({tag, "_w"},     bus.w_out, 32'd0);
    check({tag, "_round"}, 32'(bus.round_out), 32'd0);
  endtask

  // One full block: load (with optional gaps / illegal inputs), expand, hold, release.
  task automatic run_block(input int stall_at, input int stall_len, input bit rand_gaps,
                           input bit illegal, input int hold_len, input bit done_with_start);
    int idx = 0, n_valid = 0, exp_round = 0, stall_cnt = 0;
    bit v, acc, fin = 1'b0;
    build_ref();
    bus.start_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
    check("busy_after_start", 32'(bus.busy_out), 32'd1);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      check("ready", 32'(bus.word_ready_out), 32'(idx < 16));
      v = (idx < 16);
      if (v && idx == stall_at && stall_cnt < stall_len) begin v = 1'b0; stall_cnt++; end
      if (v && rand_gaps && $urandom_range(0, 2) == 0) v = 1'b0;
      bus.word_valid_in = v || (illegal && idx == 16 && $urandom_range(0, 1) == 1);
      bus.word_in       = v ? msg[idx] : $urandom;
      bus.start_in      = illegal && ($urandom_range(0, 1) == 1);
      acc = v;
      @(negedge clk);
      if (acc) idx++;
      check("valid", 32'(bus.w_valid_out), 32'(acc || (exp_round >= 16 && exp_round < 64)));
      if (bus.w_valid_out) begin
        if (exp_round < 64) begin
          check("round", 32'(bus.round_out), 32'(exp_round));
          check("word", bus.w_out, ref_w[exp_round]);
          check("phase_active", 32'(bus.state_out), (exp_round < 16) ? 32'd1 : 32'd2);
          got[exp_round] = bus.w_out;
        end else begin
          check("extra_valid", 32'(bus.w_valid_out), 32'd0);
        end
        exp_round++;
        n_valid++;
      end else begin
        check("phase_quiet", 32'(bus.state_out), (exp_round >= 64) ? 32'd3 : 32'd0);
        if (exp_round >= 64) fin = 1'b1;
      end
    end
    bus.start_in = 1'b0;
    bus.word_valid_in = 1'b0;
    check("reached_hold", 32'(fin), 32'd1);
    check("n_valid", 32'(n_valid), 32'd64);
    for (int h = 0; h < hold_len; h++) begin
      bus.start_in = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      check("hold_phase", 32'(bus.state_out), 32'd3);
      check("hold_valid", 32'(bus.w_valid_out), 32'd0);
      check("hold_w", bus.w_out, ref_w[63]);
      check("hold_round", 32'(bus.round_out), 32'd63);
      check("hold_busy", 32'(bus.busy_out), 32'd1);
    end
    bus.done_in  = 1'b1;
    bus.start_in = done_with_start;
    @(negedge clk);
    bus.done_in  = 1'b0;
    bus.start_in = 1'b0;
    check_idle("release");
    @(negedge clk);
    check("no_new_load_busy", 32'(bus.busy_out), 32'd0);
    check("no_new_load_ready", 32'(bus.word_ready_out), 32'd0);
  endtask

  initial begin
    bus.start_in = 1'b0;
    bus.word_in = '0;
    bus.word_valid_in = 1'b0;
    bus.done_in = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // Stray valid / done while idle
    bus.word_valid_in = 1'b1;
    bus.done_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.word_valid_in = 1'b0;
    bus.done_in = 1'b0;
    check_idle("idle_ignore");

    // "abc" known answer, gapless, long hold
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    run_block(-1, 0, 1'b0, 1'b0, 20, 1'b0);
    check("kat_w0",  got[0],  32'h61626380);
    check("kat_w15", got[15], 32'h00000018);
    check("kat_w16", got[16], 32'h61626380);
    check("kat_w17", got[17], 32'h000f0000);
    check("kat_w18", got[18], 32'h7da86405);
    check("kat_w19", got[19], 32'h600003c6);
    check("kat_w20", got[20], 32'h3e9d7b78);

    // Same block with a 3-cycle gap after word 5
    run_block(6, 3, 1'b0, 1'b0, 2, 1'b0);
    check("stall_w16", got[16], 32'h61626380);
    check("stall_w20", got[20], 32'h3e9d7b78);

    // Random block, random gaps, illegal start/valid, done+start together
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    run_block(-1, 0, 1'b1, 1'b1, 3, 1'b1);

    // Back-to-back random block, released on the first hold cycle
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    run_block(-1, 0, 1'b0, 1'b0, 0, 1'b0);

    // Reset during expansion, then a clean block
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    bus.start_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.word_valid_in = 1'b1;
      bus.word_in = msg[i];
      @(negedge clk);
    end
    bus.word_valid_in = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_phase", 32'(bus.state_out), 32'd2);
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    run_block(-1, 0, 1'b1, 1'b0, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
